// File: rtl/conv_window_if.sv
// Handshake and control bundle between the 3x3 window sequencer and its
// row-buffer memory, window mux and convolution pipe.
interface conv_window_if #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          start;
  logic          busy;
  logic          done;
  logic          ld_req;
  logic [RW-1:0] ld_row;
  logic [2:0]    ld_buf_onehot;
  logic          ld_ack;
  logic          buf_clr;
  logic [CW-1:0] col_cnt;
  logic [2:0]    row_sel_onehot;
  logic          win_valid;
  logic          win_ready;
  logic [RW-1:0] row_cnt;

  modport master (
    input  start, ld_ack, win_ready,
    output busy, done, ld_req, ld_row, ld_buf_onehot, buf_clr,
           col_cnt, row_sel_onehot, win_valid, row_cnt
  );

  modport slave (
    output start, ld_ack, win_ready,
    input  busy, done, ld_req, ld_row, ld_buf_onehot, buf_clr,
           col_cnt, row_sel_onehot, win_valid, row_cnt
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// 3x3 window sequencer: fills three rotating row buffers (zero-padded top and
// bottom) and streams one window per column to the convolution pipe.
module conv_window_ctrl #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_window_if.master bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [2:0] {
    IDLE, CLR_TOP, LD_MID, LD_BOT, SCAN, FIN
  } state_t;

  state_t state;
  logic   issued;  // LD_BOT has already launched its load or clear

  // Buffer that will hold row r+1: rotate the centre-row selection left by two.
  logic [2:0] bot_buf;
  assign bot_buf = {bus.row_sel_onehot[0], bus.row_sel_onehot[2:1]};

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below sees the values from the start of the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      issued             <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.ld_req         <= 1'b0;
      bus.ld_row         <= '0;
      bus.ld_buf_onehot  <= 3'b001;
      bus.buf_clr        <= 1'b0;
      bus.col_cnt        <= '0;
      bus.row_sel_onehot <= 3'b001;
      bus.win_valid      <= 1'b0;
      bus.row_cnt        <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only by the
      // transition that needs them, so each lasts exactly one cycle.
      bus.done    <= 1'b0;
      bus.buf_clr <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy          <= 1'b1;
            bus.buf_clr       <= 1'b1;
            bus.ld_buf_onehot <= 3'b001;
            state             <= CLR_TOP;
          end
        end

        CLR_TOP: begin
          bus.ld_req        <= 1'b1;
          bus.ld_row        <= '0;
          bus.ld_buf_onehot <= 3'b010;
          state             <= LD_MID;
        end

        LD_MID: begin
          if (bus.ld_ack) begin
            bus.ld_req <= 1'b0;
            issued     <= 1'b0;
            state      <= LD_BOT;
          end
        end

        LD_BOT: begin
          if (!issued) begin
            issued            <= 1'b1;
            bus.ld_buf_onehot <= bot_buf;
            if (bus.row_cnt == ROW_LAST) begin
              bus.buf_clr <= 1'b1;
            end else begin
              bus.ld_req <= 1'b1;
              bus.ld_row <= bus.row_cnt + 1'b1;
            end
          end else if (bus.buf_clr || (bus.ld_req && bus.ld_ack)) begin
            bus.ld_req    <= 1'b0;
            bus.win_valid <= 1'b1;
            bus.col_cnt   <= '0;
            state         <= SCAN;
          end
        end

        SCAN: begin
          if (bus.win_ready) begin
            if (bus.col_cnt == COL_LAST) begin
              bus.win_valid <= 1'b0;
              bus.col_cnt   <= '0;
              if (bus.row_cnt == ROW_LAST) begin
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
                state    <= FIN;
              end else begin
                bus.row_cnt        <= bus.row_cnt + 1'b1;
                bus.row_sel_onehot <= {bus.row_sel_onehot[1:0], bus.row_sel_onehot[2]};
                issued             <= 1'b0;
                state              <= LD_BOT;
              end
            end else begin
              bus.col_cnt <= bus.col_cnt + 1'b1;
            end
          end
        end

        FIN: begin
          bus.row_sel_onehot <= 3'b001;
          bus.row_cnt        <= '0;
          bus.ld_row         <= '0;
          bus.ld_buf_onehot  <= 3'b001;
          state              <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl: a 4x3 instance for frame, handshake
// and reset scenarios, and a 256x2 instance for the wide-row case.
module tb_conv_window_ctrl;
  logic clk;
  logic rst_n;

  conv_window_if #(.IMG_W(4),   .IMG_H(3)) bus_a ();
  conv_window_if #(.IMG_W(256), .IMG_H(2)) bus_b ();

  conv_window_ctrl #(.IMG_W(4),   .IMG_H(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  conv_window_ctrl #(.IMG_W(256), .IMG_H(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct { int row; int col; logic [2:0] sel; } win_t;
  typedef struct { bit clr; int row; logic [2:0] bsel; } ld_t;

  win_t exp_win_a[$], exp_win_b[$];
  ld_t  exp_ld_a[$],  exp_ld_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ack_dly_a = 2;
  int rise_a = 0, done_a = 0, rise_b = 0, done_b = 0, clr0_b = 0;
  int rise_base, done_base;
  bit req_prev_a = 0, req_prev_b = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] onehot3(input int k);
    return 3'b001 << (k % 3);
  endfunction

  function automatic int wpack(input int row, input int col, input logic [2:0] sel);
    return (row << 16) | (col << 4) | int'(sel);
  endfunction

  function automatic int lpack(input bit clr, input int row, input logic [2:0] bsel);
    return (int'(clr) << 20) | (row << 8) | int'(bsel);
  endfunction

  // Expected loads: top clear, row 0, then per centre row either row r+1 or the bottom clear.
  task automatic push_frame(input bit to_b, input int w, input int h);
    ld_t  l;
    win_t v;
    for (int k = -2; k < h; k++) begin
      if (k == -2)       l = '{clr: 1'b1, row: 0,     bsel: 3'b001};
      else if (k == -1)  l = '{clr: 1'b0, row: 0,     bsel: 3'b010};
      else if (k + 1 < h) l = '{clr: 1'b0, row: k + 1, bsel: onehot3(k + 2)};
      else               l = '{clr: 1'b1, row: 0,     bsel: onehot3(k + 2)};
      if (to_b) exp_ld_b.push_back(l); else exp_ld_a.push_back(l);
      for (int c = 0; k >= 0 && c < w; c++) begin
        v = '{row: k, col: c, sel: onehot3(k)};
        if (to_b) exp_win_b.push_back(v); else exp_win_a.push_back(v);
      end
    end
  endtask

  // Memory responders: ack a fixed number of cycles after the request (0 = same cycle).
  initial begin
    forever begin
      @(negedge clk);
      if (bus_a.ld_req && !bus_a.ld_ack) begin
        repeat (ack_dly_a) @(negedge clk);
        bus_a.ld_ack = 1'b1;
        @(negedge clk);
        bus_a.ld_ack = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus_b.ld_req && !bus_b.ld_ack) begin
        repeat (2) @(negedge clk);
        bus_b.ld_ack = 1'b1;
        @(negedge clk);
        bus_b.ld_ack = 1'b0;
      end
    end
  end

  // Monitors: pop and compare every accepted window, completed load and clear.
  initial begin
    win_t e;
    ld_t  l;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bus_a.win_valid && bus_a.win_ready) begin
          if (exp_win_a.size() == 0)
            check("win_a_unexpected", wpack(bus_a.row_cnt, bus_a.col_cnt, bus_a.row_sel_onehot), -1);
          else begin
            e = exp_win_a.pop_front();
            check("win_a", wpack(bus_a.row_cnt, bus_a.col_cnt, bus_a.row_sel_onehot),
                  wpack(e.row, e.col, e.sel));
          end
        end
        if ((bus_a.ld_req && bus_a.ld_ack) || bus_a.buf_clr) begin
          if (exp_ld_a.size() == 0)
            check("ld_a_unexpected", lpack(bus_a.buf_clr, bus_a.ld_row, bus_a.ld_buf_onehot), -1);
          else begin
            l = exp_ld_a.pop_front();
            check("ld_a", bus_a.buf_clr ? lpack(1'b1, 0, bus_a.ld_buf_onehot)
                                        : lpack(1'b0, bus_a.ld_row, bus_a.ld_buf_onehot),
                  lpack(l.clr, l.row, l.bsel));
          end
        end
        if (bus_a.ld_req && !req_prev_a) rise_a++;
        if (bus_a.done) done_a++;
      end
      req_prev_a = bus_a.ld_req;
    end
  end

  initial begin
    win_t e;
    ld_t  l;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bus_b.win_valid && bus_b.win_ready) begin
          if (exp_win_b.size() == 0)
            check("win_b_unexpected", wpack(bus_b.row_cnt, bus_b.col_cnt, bus_b.row_sel_onehot), -1);
          else begin
            e = exp_win_b.pop_front();
            check("win_b", wpack(bus_b.row_cnt, bus_b.col_cnt, bus_b.row_sel_onehot),
                  wpack(e.row, e.col, e.sel));
          end
        end
        if ((bus_b.ld_req && bus_b.ld_ack) || bus_b.buf_clr) begin
          if (exp_ld_b.size() == 0)
            check("ld_b_unexpected", lpack(bus_b.buf_clr, bus_b.ld_row, bus_b.ld_buf_onehot), -1);
          else begin
            l = exp_ld_b.pop_front();
            check("ld_b", bus_b.buf_clr ? lpack(1'b1, 0, bus_b.ld_buf_onehot)
                                        : lpack(1'b0, bus_b.ld_row, bus_b.ld_buf_onehot),
                  lpack(l.clr, l.row, l.bsel));
          end
        end
        if (bus_b.buf_clr && bus_b.ld_buf_onehot == 3'b001) clr0_b++;
        if (bus_b.ld_req && !req_prev_b) rise_b++;
        if (bus_b.done) done_b++;
      end
      req_prev_b = bus_b.ld_req;
    end
  end

  task automatic check_reset_a(input string name);
    check({name, "_flags"}, {bus_a.busy, bus_a.done, bus_a.ld_req, bus_a.buf_clr, bus_a.win_valid}, 0);
    check({name, "_onehots"}, {bus_a.ld_buf_onehot, bus_a.row_sel_onehot}, 6'b001_001);
    check({name, "_counts"}, {bus_a.col_cnt, bus_a.row_cnt, bus_a.ld_row}, 0);
  endtask

  task automatic launch_a();
    rise_base = rise_a;
    done_base = done_a;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  // Waits (bounded) for done, optionally re-pulses start in the done cycle, then audits the frame.
  task automatic finish_a(input string name, input bit start_in_done);
    for (int i = 0; i < 2000 && !bus_a.done; i++) @(negedge clk);
    check({name, "_done_seen"}, bus_a.done, 1);
    check({name, "_busy_in_done"}, bus_a.busy, 0);
    if (start_in_done) bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (6) @(negedge clk);
    check({name, "_no_restart"}, bus_a.busy, 0);
    check({name, "_done_count"}, done_a - done_base, 1);
    check({name, "_ld_req_rises"}, rise_a - rise_base, 3);
    check({name, "_win_left"}, exp_win_a.size(), 0);
    check({name, "_ld_left"}, exp_ld_a.size(), 0);
    check({name, "_idle_onehots"}, {bus_a.ld_buf_onehot, bus_a.row_sel_onehot}, 6'b001_001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.ld_ack = 1'b0; bus_a.win_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.ld_ack = 1'b0; bus_b.win_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_a("reset_a");
    check("reset_b_flags", {bus_b.busy, bus_b.done, bus_b.ld_req, bus_b.win_valid}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: basic frame with 2-cycle ack latency and ready always high.
    push_frame(1'b0, 4, 3);
    launch_a();
    check("t1_busy_after_start", bus_a.busy, 1);
    finish_a("t1", 1'b0);

    // T2: backpressure at column 2 of row 1.
    push_frame(1'b0, 4, 3);
    launch_a();
    for (int i = 0; i < 500; i++) begin
      if (bus_a.win_valid && bus_a.row_cnt == 1 && bus_a.col_cnt == 2) break;
      @(negedge clk);
    end
    check("t2_reach_r1c2", {bus_a.win_valid, bus_a.row_cnt, bus_a.col_cnt}, {1'b1, 2'd1, 2'd2});
    bus_a.win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold", {bus_a.win_valid, bus_a.col_cnt, bus_a.row_sel_onehot}, {1'b1, 2'd2, 3'b010});
    end
    bus_a.win_ready = 1'b1;
    finish_a("t2", 1'b0);

    // T3: start while busy and in the done cycle, then a clean frame.
    push_frame(1'b0, 4, 3);
    launch_a();
    repeat (6) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    finish_a("t3", 1'b1);
    push_frame(1'b0, 4, 3);
    launch_a();
    finish_a("t3_again", 1'b0);

    // T4: asynchronous reset in the middle of row 1, then a full frame.
    push_frame(1'b0, 4, 3);
    launch_a();
    for (int i = 0; i < 500; i++) begin
      if (bus_a.win_valid && bus_a.row_cnt == 1 && bus_a.col_cnt == 2) break;
      @(negedge clk);
    end
    check("t4_reach_r1c2", {bus_a.win_valid, bus_a.row_cnt, bus_a.col_cnt}, {1'b1, 2'd1, 2'd2});
    #3 rst_n = 1'b0;
    #1 check_reset_a("t4_async_reset");
    exp_win_a.delete();
    exp_ld_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_frame(1'b0, 4, 3);
    launch_a();
    finish_a("t4_after", 1'b0);

    // T5: every ld_ack arrives in the first ld_req cycle.
    ack_dly_a = 0;
    push_frame(1'b0, 4, 3);
    launch_a();
    finish_a("t5", 1'b0);

    // T6: full-width rows on the 256x2 instance.
    push_frame(1'b1, 256, 2);
    @(negedge clk);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    for (int i = 0; i < 3000 && !bus_b.done; i++) @(negedge clk);
    check("t6_done_seen", bus_b.done, 1);
    repeat (4) @(negedge clk);
    check("t6_done_count", done_b, 1);
    check("t6_buf0_clears", clr0_b, 2);
    check("t6_ld_req_rises", rise_b, 2);
    check("t6_win_left", exp_win_b.size(), 0);
    check("t6_ld_left", exp_ld_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
